inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Instruction fetch front end of the out-of-order RV32I core. It holds the fetch PC and reads instruction words through a small direct-mapped instruction cache, falling back to the memory controller on a miss. It presents one instruction at a time to the decoder over a valid/issue handshake and redirects to the decoder-supplied next PC or the ROB correct PC.

## Interface
- `RESET_PC`, default 32'h0: fetch PC after reset.
- `ICACHE_LINES`, default 16: number of one-word cache lines, power of two ≥2. IDX = log2(ICACHE_LINES).
- `clk_in`  in  1  system clock; all state on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready; when low, every register holds its value.
- `mem_req`  out  1  instruction read request to the memory controller.
- `mem_addr`  out  32  word address of the request; equals PC.
- `mem_ready`  in  1  one-cycle pulse: `mem_data` valid for the outstanding request.
- `mem_data`  in  32  returned instruction word.
- `valid`  out  1  `inst`/`inst_addr` hold an instruction for the decoder.
- `inst`  out  32  instruction word.
- `inst_addr`  out  32  address of `inst`.
- `issue_signal`  in  1  decoder consumed the presented instruction this cycle.
- `next_pc`  in  32  decoder's next fetch PC, sampled with `issue_signal`.
- `wrong_predicted`  in  1  ROB flush.
- `correct_pc`  in  32  redirect target, sampled with `wrong_predicted`.

## Operation
- Registers: `pc`, `state` ∈ {IDLE, FETCH, HOLD}, `discard`, cache arrays `cv[L]`, `ctag[L]` (32−2−IDX bits), `cdata[L]` (32 bits).
- Index = `pc[IDX+1:2]`; tag = `pc[31:IDX+2]`; `pc[1:0]` is always 0.
- Reset (`rst_in`=0, immediate): `pc`=RESET_PC, state IDLE, `mem_req`=0, `mem_addr`=0, `valid`=0, `inst`=0, `inst_addr`=0, `discard`=0, all `cv`=0.
- Priority in every state: `wrong_predicted` > `mem_ready` handling > `issue_signal`.
- IDLE:
  - `wrong_predicted`: `pc`←`correct_pc`, stay IDLE, no lookup.
  - Hit (`cv[idx]` and tag match): `inst`←`cdata[idx]`, `inst_addr`←`pc`, `valid`←1, →HOLD.
  - Miss: `mem_req`←1, `mem_addr`←`pc`, →FETCH.
- FETCH: `mem_req`/`mem_addr` held stable until `mem_ready`.
  - `wrong_predicted` without `mem_ready`: `pc`←`correct_pc`, `discard`←1; the request is not cancelled.
  - `mem_ready`: fill line at index/tag of `mem_addr` (always, even if discarding); `mem_req`←0.
    - If `discard` or same-cycle `wrong_predicted`: no present, `discard`←0, →IDLE; same-cycle flush also sets `pc`←`correct_pc`.
    - Otherwise: `inst`←`mem_data`, `inst_addr`←`pc`, `valid`←1, →HOLD.
- HOLD:
  - `wrong_predicted`: `valid`←0, `pc`←`correct_pc`, →IDLE.
  - Else if `issue_signal`: `valid`←0, `pc`←`next_pc`, →IDLE.
  - Else hold `valid`, `inst` and `inst_addr` unchanged. Covers decoder stalls such as a full ROB/RS/LSB or a JALR waiting on a dependency.
- `issue_signal` is ignored when `valid`=0. `mem_ready` is ignored outside FETCH.
- Cache is never invalidated except by reset (no self-modifying code).

## Timing
- Hit: PC entering IDLE at cycle N gives `valid`=1 at N+1. Issue-to-issue throughput is 1 instruction per 2 cycles.
- Miss: `mem_req`=1 at N+1; `mem_ready` at cycle M gives `valid`=1 at M+1.
- Flush recovery: `wrong_predicted` at cycle F puts the new PC in IDLE at F+1. If a request is outstanding, the new fetch starts only after that request's `mem_ready`.
- `rdy_in`=0 freezes every register, including cache fills; a `mem_ready` arriving during a freeze is lost. The memory controller is frozen by the same signal, so this does not occur.
- Asynchronous reset mid-FETCH drops the request at once: `mem_req`=0 before the next edge.

## Test plan
- Reset, RESET_PC=0: release reset → `mem_req`=1, `mem_addr`=0; `mem_ready` with 32'h00500093 → next cycle `valid`=1, `inst`=32'h00500093, `inst_addr`=0.
- Sequential miss: in HOLD, `issue_signal`=1, `next_pc`=4 → `valid`=0, then `mem_req`=1, `mem_addr`=4; stays in FETCH for 5 cycles until `mem_ready`.
- Cache hit: after fetching 0 and 4, issue with `next_pc`=0 → `valid`=1 with `inst`=32'h00500093 one cycle later, `mem_req` never asserted.
- Stall: HOLD with `issue_signal`=0 for 6 cycles → `valid`=1, `inst` and `inst_addr` stable throughout.
- Flush in FETCH: fetching 8, `wrong_predicted`=1 with `correct_pc`=32'h100, then `mem_ready` → `valid` stays 0. Next request has `mem_addr`=32'h100; a later fetch of 8 hits.
- Freeze/reset: `rdy_in`=0 for 3 cycles in HOLD → no change. `rst_in`=0 mid-FETCH → `mem_req`=0 immediately, `pc`=RESET_PC, all lines invalid.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: fetch PC, direct-mapped one-word I-cache,
// memory-controller refill and a valid/issue handshake to the decoder.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        issue_signal,
    input  logic [31:0] next_pc,
    input  logic        wrong_predicted,
    input  logic [31:0] correct_pc
);
    localparam int IDX   = $clog2(ICACHE_LINES);
    localparam int TAG_W = 32 - 2 - IDX;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t                  r_state;
    logic [31:0]             r_pc;
    logic                    r_discard;
    logic                    r_mem_req;
    logic [31:0]             r_mem_addr;
    logic                    r_valid;
    logic [31:0]             r_inst;
    logic [31:0]             r_inst_addr;
    logic [ICACHE_LINES-1:0] r_cv;
    logic [TAG_W-1:0]        r_ctag  [ICACHE_LINES];
    logic [31:0]             r_cdata [ICACHE_LINES];

    logic [IDX-1:0]   w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX-1:0]   w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_hit;
    logic             w_fill;

    assign w_idx      = r_pc[IDX+1:2];
    assign w_tag      = r_pc[31:IDX+2];
    assign w_fill_idx = r_mem_addr[IDX+1:2];
    assign w_fill_tag = r_mem_addr[31:IDX+2];
    assign w_hit      = r_cv[w_idx] && (r_ctag[w_idx] == w_tag);
    // Refill happens on every response, including ones being discarded after a flush.
    assign w_fill     = rdy_in && (r_state == FETCH) && mem_ready;

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign valid     = r_valid;
    assign inst      = r_inst;
    assign inst_addr = r_inst_addr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_discard   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_valid     <= 1'b0;
            r_inst      <= 32'h0;
            r_inst_addr <= 32'h0;
            r_cv        <= '0;
        end else if (rdy_in) begin
            case (r_state)
                IDLE: begin
                    if (wrong_predicted) begin
                        r_pc <= correct_pc;
                    end else if (w_hit) begin
                        r_inst      <= r_cdata[w_idx];
                        r_inst_addr <= r_pc;
                        r_valid     <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        r_cv[w_fill_idx] <= 1'b1;
                        r_mem_req        <= 1'b0;
                        if (r_discard || wrong_predicted) begin
                            r_discard <= 1'b0;
                            r_state   <= IDLE;
                            if (wrong_predicted) begin
                                r_pc <= correct_pc;
                            end
                        end else begin
                            r_inst      <= mem_data;
                            r_inst_addr <= r_pc;
                            r_valid     <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end else if (wrong_predicted) begin
                        // The bus request cannot be cancelled; drop its response instead.
                        r_pc      <= correct_pc;
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (wrong_predicted) begin
                        r_valid <= 1'b0;
                        r_pc    <= correct_pc;
                        r_state <= IDLE;
                    end else if (issue_signal) begin
                        r_valid <= 1'b0;
                        r_pc    <= next_pc;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; line validity lives in r_cv.
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_ctag[w_fill_idx]  <= w_fill_tag;
            r_cdata[w_fill_idx] <= mem_data;
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: scoreboard queues for presented
// instructions and memory requests, checked by independent monitors.
module tb_inst_fetcher;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        issue_signal = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        wrong_predicted = 1'b0;
    logic [31:0] correct_pc = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [31:0] inst; logic [31:0] addr; } pres_t;
    pres_t       exp_pres[$];
    logic [31:0] exp_req[$];

    inst_fetcher #(.RESET_PC(32'h0), .ICACHE_LINES(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data),
        .valid(valid), .inst(inst), .inst_addr(inst_addr),
        .issue_signal(issue_signal), .next_pc(next_pc),
        .wrong_predicted(wrong_predicted), .correct_pc(correct_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Presentation monitor: each rising valid pops one expectation; while held, must stay stable.
    logic        prev_valid = 1'b0;
    logic [31:0] held_inst, held_addr;
    always @(negedge clk_in) begin
        if (valid && !prev_valid) begin
            if (exp_pres.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_present: inst %h addr %h, none expected", inst, inst_addr);
            end else begin
                pres_t e;
                e = exp_pres.pop_front();
                check("present_inst", inst, e.inst);
                check("present_addr", inst_addr, e.addr);
            end
            held_inst = inst;
            held_addr = inst_addr;
        end else if (valid && prev_valid) begin
            check("hold_inst_stable", inst, held_inst);
            check("hold_addr_stable", inst_addr, held_addr);
        end
        prev_valid = valid;
    end

    // Request monitor: each rising mem_req pops one expected address.
    logic prev_req = 1'b0;
    always @(negedge clk_in) begin
        if (mem_req && !prev_req) begin
            if (exp_req.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_req: addr %h, none expected", mem_addr);
            end else begin
                check("req_addr", mem_addr, exp_req.pop_front());
            end
        end
        prev_req = mem_req;
    end

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 50) begin @(negedge clk_in); n++; end
        if (!mem_req) begin n_cmp++; n_err++; $display("FAIL wait_req: timeout, mem_req 0 required 1"); end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid && n < 50) begin @(negedge clk_in); n++; end
        if (!valid) begin n_cmp++; n_err++; $display("FAIL wait_valid: timeout, valid 0 required 1"); end
    endtask

    // Answer the outstanding request after `delay` extra cycles, checking it is held stable.
    task automatic serve(input logic [31:0] data, input int delay, input logic [31:0] addr);
        wait_req();
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_in);
            check("fetch_req_held", {31'b0, mem_req}, 32'd1);
            check("fetch_addr_held", mem_addr, addr);
        end
        mem_ready = 1'b1;
        mem_data  = data;
        @(negedge clk_in);
        mem_ready = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc);
        issue_signal = 1'b1;
        next_pc      = pc;
        @(negedge clk_in);
        issue_signal = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_addr", inst_addr, 32'h0);

        // First miss at RESET_PC
        exp_req.push_back(32'h0);
        exp_pres.push_back('{32'h00500093, 32'h0});
        rst_in = 1'b1;
        serve(32'h00500093, 0, 32'h0);
        check("valid_after_ready", {31'b0, valid}, 32'd1);

        // Decoder stall for 6 cycles
        repeat (6) begin
            @(negedge clk_in);
            check("stall_valid", {31'b0, valid}, 32'd1);
        end

        // Sequential miss with a 5-cycle memory latency
        exp_req.push_back(32'h4);
        exp_pres.push_back('{32'h00100113, 32'h4});
        issue(32'h4);
        check("issue_drops_valid", {31'b0, valid}, 32'd0);
        serve(32'h00100113, 4, 32'h4);
        check("valid_after_slow_ready", {31'b0, valid}, 32'd1);

        // Cache hit on 0: valid one cycle after entering IDLE, no request
        exp_pres.push_back('{32'h00500093, 32'h0});
        issue(32'h0);
        check("hit_idle_valid", {31'b0, valid}, 32'd0);
        @(negedge clk_in);
        check("hit_valid", {31'b0, valid}, 32'd1);
        check("hit_no_req", {31'b0, mem_req}, 32'd0);

        // Flush while fetching 8: response is discarded, then refetch at 0x100
        exp_req.push_back(32'h8);
        issue(32'h8);
        wait_req();
        wrong_predicted = 1'b1;
        correct_pc      = 32'h100;
        @(negedge clk_in);
        wrong_predicted = 1'b0;
        check("flush_req_kept", {31'b0, mem_req}, 32'd1);
        check("flush_addr_kept", mem_addr, 32'h8);
        exp_req.push_back(32'h100);
        exp_pres.push_back('{32'h06400193, 32'h100});
        mem_ready = 1'b1;
        mem_data  = 32'h00000013;
        @(negedge clk_in);
        mem_ready = 1'b0;
        check("discard_no_valid", {31'b0, valid}, 32'd0);
        check("discard_req_low", {31'b0, mem_req}, 32'd0);
        @(negedge clk_in);
        check("discard_still_no_valid", {31'b0, valid}, 32'd0);
        serve(32'h06400193, 1, 32'h100);
        check("valid_after_refetch", {31'b0, valid}, 32'd1);

        // Discarded response still filled the line for 8
        exp_pres.push_back('{32'h00000013, 32'h8});
        issue(32'h8);
        @(negedge clk_in);
        check("hit8_valid", {31'b0, valid}, 32'd1);
        check("hit8_no_req", {31'b0, mem_req}, 32'd0);

        // Freeze in HOLD with an issue attempt: nothing may change
        rdy_in       = 1'b0;
        issue_signal = 1'b1;
        next_pc      = 32'h200;
        repeat (3) begin
            @(negedge clk_in);
            check("freeze_valid", {31'b0, valid}, 32'd1);
            check("freeze_inst", inst, 32'h00000013);
        end
        issue_signal = 1'b0;
        rdy_in       = 1'b1;
        @(negedge clk_in);
        check("unfreeze_valid", {31'b0, valid}, 32'd1);

        // Flush in HOLD to a cached PC
        exp_pres.push_back('{32'h00100113, 32'h4});
        wrong_predicted = 1'b1;
        correct_pc      = 32'h4;
        @(negedge clk_in);
        wrong_predicted = 1'b0;
        check("hold_flush_valid_low", {31'b0, valid}, 32'd0);
        @(negedge clk_in);
        check("hold_flush_hit", {31'b0, valid}, 32'd1);
        check("hold_flush_no_req", {31'b0, mem_req}, 32'd0);

        // Asynchronous reset mid-fetch
        exp_req.push_back(32'h300);
        issue(32'h300);
        wait_req();
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_req", {31'b0, mem_req}, 32'd0);
        check("async_rst_valid", {31'b0, valid}, 32'd0);
        repeat (2) @(negedge clk_in);
        exp_req.push_back(32'h0);
        exp_pres.push_back('{32'h00500093, 32'h0});
        rst_in = 1'b1;
        serve(32'h00500093, 0, 32'h0);
        wait_valid();
        // Line for 4 was valid before reset; it must miss now
        exp_req.push_back(32'h4);
        exp_pres.push_back('{32'h00100113, 32'h4});
        issue(32'h4);
        serve(32'h00100113, 2, 32'h4);
        wait_valid();

        repeat (3) @(negedge clk_in);
        check("pres_queue_empty", exp_pres.size(), 32'd0);
        check("req_queue_empty", exp_req.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
